// File: rtl/iter_mul_radix4.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one radix-4 multiplier digit per cycle, exact or truncated.
// Latency: 1..WIDTH/2 steps after accept; result held in DONE until out_ready.
module iter_mul_radix4 #(
  parameter int WIDTH      = 8,
  parameter int APPROX_LSB = 4,
  parameter int EARLY_TERM = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 out_approx,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);
  localparam logic [PW-1:0] MASK = {PW{1'b1}} << APPROX_LSB;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_r, b_r;
  logic              mode_r;
  logic [PW-1:0]     acc, pp;
  logic [CW-1:0]     cnt;
  logic              last_step;

  // Partial product of the current digit, shifted to weight 4^cnt and optionally truncated.
  always_comb begin
    pp = PW'(a_r) * PW'(b_r[1:0]);
    pp = pp << {cnt, 1'b0};
    if (mode_r) pp = pp & MASK;
    last_step = (cnt == LAST) || ((EARLY_TERM != 0) && (b_r[WIDTH-1:2] == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r    <= in_a;
          b_r    <= in_b;
          mode_r <= in_approx;
          acc    <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          acc <= acc + pp;
          b_r <= b_r >> 2;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state == BUSY);
  assign out_valid  = (state == DONE);
  assign out_p      = acc;
  assign out_approx = mode_r;

endmodule

// File: tb/tb_iter_mul_radix4.sv
// Bench for iter_mul_radix4: early-terminating and fixed-length instances driven in lockstep.
module tb_iter_mul_radix4;
  localparam int W  = 8;
  localparam int AL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          in_approx = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready_e, out_valid_e, out_approx_e, busy_e;
  logic          in_ready_f, out_valid_f, out_approx_f, busy_f;
  logic [2*W-1:0] out_p_e, out_p_f;

  int checks = 0;
  int failures = 0;

  iter_mul_radix4 #(.WIDTH(W), .APPROX_LSB(AL), .EARLY_TERM(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid_e), .out_ready(out_ready), .out_p(out_p_e),
    .out_approx(out_approx_e), .busy(busy_e));

  iter_mul_radix4 #(.WIDTH(W), .APPROX_LSB(AL), .EARLY_TERM(0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid_f), .out_ready(out_ready), .out_p(out_p_f),
    .out_approx(out_approx_f), .busy(busy_f));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: sum of radix-4 digit products at weight 4^i, low AL columns dropped when approximate.
  function automatic logic [2*W-1:0] model_p(input int a, input int b, input bit m);
    longint sum = 0;
    for (int i = 0; i < W / 2; i++) begin
      longint pp = longint'(a) * ((b >> (2 * i)) & 3) * (longint'(1) << (2 * i));
      if (m) pp = pp - (pp % (longint'(1) << AL));
      sum += pp;
    end
    return (2*W)'(sum);
  endfunction

  function automatic int model_steps(input int b);
    int s = 1;
    for (int i = 0; i < W / 2; i++)
      if (((b >> (2 * i)) & 3) != 0) s = i + 1;
    return s;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(in_ready_e && in_ready_f) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 1, 0);
  endtask

  // One operation on both instances with random out_ready stalls; checks result, mode, latency, stability.
  task automatic run_op(input int a, input int b, input bit m, input int stall,
                        input logic [2*W-1:0] exp_p, input int exp_s);
    bit seen_e = 0, seen_f = 0, done_e = 0, done_f = 0;
    int k = 0, lat_e = 0, lat_f = 0;
    logic [2*W-1:0] p_e = '0, p_f = '0;
    logic ap_e = 0, ap_f = 0;
    wait_idle();
    in_a = W'(a); in_b = W'(b); in_approx = m; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_approx = ~m;
    while (!(done_e && done_f) && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      out_ready = ($urandom_range(99) >= stall);
      if (!done_e && out_valid_e) begin
        if (!seen_e) begin seen_e = 1; lat_e = k; p_e = out_p_e; ap_e = out_approx_e; end
        else if (out_p_e !== p_e || out_approx_e !== ap_e) chk("stable_e", 0, 1);
        if (out_ready) done_e = 1;
      end
      if (!done_f && out_valid_f) begin
        if (!seen_f) begin seen_f = 1; lat_f = k; p_f = out_p_f; ap_f = out_approx_f; end
        else if (out_p_f !== p_f || out_approx_f !== ap_f) chk("stable_f", 0, 1);
        if (out_ready) done_f = 1;
      end
    end
    chk("done_e", 32'(done_e), 1);
    chk("done_f", 32'(done_f), 1);
    chk("p_early", 32'(p_e), 32'(exp_p));
    chk("p_full", 32'(p_f), 32'(exp_p));
    chk("mode_early", 32'(ap_e), 32'(m));
    chk("mode_full", 32'(ap_f), 32'(m));
    chk("lat_early", lat_e, exp_s);
    chk("lat_full", lat_f, W / 2);
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct {
    int a; int b; bit m; logic [2*W-1:0] p; int s;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    vecs[0]  = '{255, 255, 1'b0, 16'hFE01, 4};
    vecs[1]  = '{255, 255, 1'b1, 16'd65008, 4};
    vecs[2]  = '{200, 3,   1'b0, 16'h0258, 1};
    vecs[3]  = '{200, 0,   1'b0, 16'd0, 1};
    vecs[4]  = '{13,  11,  1'b0, 16'd143, 2};
    vecs[5]  = '{7,   9,   1'b0, 16'd63, 2};
    vecs[6]  = '{0,   255, 1'b1, 16'd0, 4};
    vecs[7]  = '{255, 64,  1'b0, 16'd16320, 4};
    vecs[8]  = '{100, 16,  1'b1, 16'd1600, 3};
    vecs[9]  = '{15,  1,   1'b1, 16'd0, 1};
    vecs[10] = '{37,  5,   1'b1, 16'd176, 2};

    #12;
    chk("rst_out_valid", 32'(out_valid_e), 0);
    chk("rst_out_p", 32'(out_p_e), 0);
    chk("rst_busy", 32'(busy_e), 0);
    chk("rst_out_approx", 32'(out_approx_e), 0);
    chk("rst_in_ready", 32'(in_ready_e), 1);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].m, 0, vecs[i].p, vecs[i].s);

    // Backpressure: result held, no new operand taken until the edge after the handshake.
    wait_idle();
    in_a = 8'd13; in_b = 8'd11; in_approx = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_a = W'($urandom); in_b = W'($urandom); in_valid = 1'b1;
      chk("bp_p_e", 32'(out_p_e), 143);
      chk("bp_p_f", 32'(out_p_f), 143);
      chk("bp_valid", 32'(out_valid_e & out_valid_f), 1);
      chk("bp_in_ready", 32'(in_ready_e | in_ready_f), 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("bp_p_after_pulses", 32'(out_p_e), 143);
    in_a = 8'd6; in_b = 8'd7; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid_e), 0);
    chk("bp_release_ready", 32'(in_ready_e), 1);
    chk("bp_release_busy", 32'(busy_e), 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_accept", 32'(busy_e & busy_f), 1);
    wait_idle();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of the second step.
    wait_idle();
    in_a = 8'd255; in_b = 8'd255; in_approx = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid_e | out_valid_f), 0);
    chk("arst_out_p", 32'(out_p_e | out_p_f), 0);
    chk("arst_busy", 32'(busy_e | busy_f), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 32'(in_ready_e & in_ready_f), 1);
    chk("arst_no_stale", 32'(out_valid_e | out_valid_f), 0);
    run_op(7, 9, 1'b0, 0, 16'd63, 2);

    // Random sweep with small multipliers mixed in to exercise early termination.
    n = 0;
    repeat (2000) begin
      int a = int'($urandom_range(255));
      int b = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(255));
      bit m = 1'($urandom);
      run_op(a, b, m, int'($urandom_range(60)), model_p(a, b, m), model_steps(b));
      n++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
